// File: rtl/mux_arbiter.sv
// mux_arbiter: merges four first-word-fall-through class FIFOs into one
// tagged stream. A round-robin arbiter pops at most one FIFO per cycle, and
// the popped word appears one cycle later on data_out together with its
// 2-bit class. Per-class wrap-around counters record forwarded words.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   data_in0..data_in3      head word of each FIFO (valid while empty_i=0)
//   empty_0..empty_3        FIFO empty flags
//   pause                   downstream almost-full; blocks all pops
//   pop_0..pop_3            combinational pop strobes (one-hot or zero)
//   data_out, class_out     registered merged word and its class
//   valid_out               registered, data_out/class_out valid
//   idle                    registered, high while the FSM is IDLE
//   count_0..count_3        per-class forwarded-word counters
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | no word popped in the previous cycle
// RUN   | a word was popped in the previous cycle
module mux_arbiter #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              empty_3,
  input  logic              pause,
  output logic              pop_0,
  output logic              pop_1,
  output logic              pop_2,
  output logic              pop_3,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        class_out,
  output logic              valid_out,
  output logic              idle,
  output logic [CNT_W-1:0]  count_0,
  output logic [CNT_W-1:0]  count_1,
  output logic [CNT_W-1:0]  count_2,
  output logic [CNT_W-1:0]  count_3
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state, state_nxt;
  logic [1:0]         last_grant;
  logic [3:0]         eligible;
  logic [1:0]         grant;
  logic               grant_vld;
  logic [1:0]         idx;
  logic [DATA_W-1:0]  data_sel;
  logic [CNT_W-1:0]   cnt [4];

  // reset is folded in so no pop can escape during the reset cycle itself
  assign eligible = {~empty_3, ~empty_2, ~empty_1, ~empty_0} & {4{~pause & ~reset}};

  // Search starts just after the last winner; the first eligible class wins.
  always_comb begin
    grant     = 2'd0;
    grant_vld = 1'b0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  assign pop_0 = grant_vld && (grant == 2'd0);
  assign pop_1 = grant_vld && (grant == 2'd1);
  assign pop_2 = grant_vld && (grant == 2'd2);
  assign pop_3 = grant_vld && (grant == 2'd3);

  always_comb begin
    data_sel = data_in0;
    case (grant)
      2'd0:    data_sel = data_in0;
      2'd1:    data_sel = data_in1;
      2'd2:    data_sel = data_in2;
      default: data_sel = data_in3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_vld)  state_nxt = S_RUN;
      S_RUN:   if (!grant_vld) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 2'b11;
      data_out   <= '0;
      class_out  <= 2'd0;
      valid_out  <= 1'b0;
    end else begin
      state     <= state_nxt;
      valid_out <= grant_vld;
      if (grant_vld) begin
        data_out   <= data_sel;
        class_out  <= grant;
        last_grant <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset)
        cnt[i] <= '0;
      else if (grant_vld && grant == 2'(i))
        cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign idle    = (state == S_IDLE);
  assign count_0 = cnt[0];
  assign count_1 = cnt[1];
  assign count_2 = cnt[2];
  assign count_3 = cnt[3];

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

- Merges four 12-bit class queues back into one tagged stream; the egress counterpart of the class demux.
- Pops the four first-word-fall-through FIFOs fed by the demux with round-robin fairness and emits one word per cycle with its 2-bit class.
- Honours a downstream pause and keeps per-class wrap-around word counters for debug.

## Interface
- DATA_W, 12, word width
- CNT_W, 8, width of each per-class word counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- data_in0..data_in3  in  DATA_W each  head word of FIFO i (valid whenever empty_i=0)
- empty_0..empty_3  in  1 each  FIFO i empty flag
- pause  in  1  downstream cannot accept; no pops while high
- pop_0..pop_3  out  1 each  pop strobe to FIFO i (combinational, one-hot or zero)
- data_out  out  DATA_W  registered merged word
- class_out  out  2  registered class of data_out
- valid_out  out  1  registered, data_out/class_out valid this cycle
- idle  out  1  registered, high when FSM is IDLE
- count_0..count_3  out  CNT_W each  words forwarded per class

## Operation
- Registered state:
  - last_grant[1:0]: reset 2'b11, so class 0 has first priority.
  - FSM: IDLE/RUN.
  - Output registers and counters.
- Eligible set: class i is eligible when empty_i=0 and pause=0 and reset=0.
- Arbitration (combinational):
  - Search order: last_grant+1, +2, +3, +4 (mod 4).
  - The first eligible class is granted and its pop_i=1; all other pops are 0.
  - With no eligible class, all pops are 0.
  - At most one pop per cycle, ever.
- On the clock edge after a grant g:
  - data_out=data_in_g, class_out=g, valid_out=1.
  - last_grant=g.
  - count_g increments, wrapping from 2^CNT_W-1 to 0.
- No grant: valid_out=0, data_out and class_out hold their previous values, last_grant holds.
- FSM:
  - IDLE -> RUN when any pop is asserted.
  - RUN -> IDLE when no pop is asserted.
  - idle=1 in IDLE.
- Reset values:
  - All pops 0 while reset is high, regardless of empties.
  - data_out=0, class_out=0, valid_out=0, idle=1, count_0..3=0, last_grant=2'b11, FSM=IDLE.

## Timing
- Latency: pop_i in cycle N -> word on data_out with valid_out=1 in cycle N+1.
- Throughput: one word per cycle while any FIFO is non-empty and pause=0.
- Pause:
  - Pause high in cycle N -> no pop in N -> valid_out=0 in N+1.
  - A word popped in N-1 still appears in N; downstream must absorb one in-flight word, so pause is an almost-full indication.
- Single source: a sole non-empty FIFO is popped every cycle, back to back.
- Empty at the edge: if empty_i rises in the same cycle it would be granted, i is not eligible and the next class in order is granted that cycle.
- Reset mid-stream:
  - Pops drop in the reset cycle itself.
  - The next edge clears all outputs; any in-flight word is discarded.
  - After reset, priority restarts at class 0.
- Counter wrap: count_i at 255 (CNT_W=8) plus a pop -> 0, with no flag and no stall.

## Test plan
- Reset:
  - Stimulus: reset=1 with all empty_i=0 for 2 cycles.
  - Response: all pops 0, valid_out=0, idle=1, count_0..3=0.
  - Then reset=0: pop_0 in the next cycle, class_out=0 one cycle later.
- Round robin:
  - Stimulus: all four FIFOs non-empty with heads 0x0A0, 0x1A1, 0x2A2, 0x3A3, pause=0.
  - Response: class_out sequence 0,1,2,3,0 on consecutive cycles with the matching data, valid_out=1 continuously.
- Skip empties:
  - Stimulus: only FIFOs 1 and 3 non-empty.
  - Response: pops alternate 1,3,1,3, and count_1 and count_3 each +2 after 4 cycles.
- Pause:
  - Stimulus: all non-empty, pause high for cycles 5-7.
  - Response: no pops in cycles 5-7; valid_out=1 in cycle 5 (in-flight word), 0 in cycles 6-8.
  - Arbitration resumes at last_grant+1 with no class skipped.
- Counter wrap:
  - Stimulus: FIFO 2 alone non-empty for 257 pops.
  - Response: count_2 = 1 after wrap, one word per cycle throughout.
- Reset mid-stream:
  - Stimulus: reset=1 for one cycle during back-to-back traffic.
  - Response: pops 0 in that cycle, valid_out=0 and counters 0 the next cycle, first grant after reset goes to the lowest non-empty class.
